truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Response-side counterpart to our combinational truth-table stimulus benches.
//  Accepts one input vector at a time and waits a settle delay. Then samples the
//  DUT outputs and compares them with an expected-table parameter.
//  Tracks coverage of all 2^N_IN vectors and counts mismatches, then reports
//  done/pass. It is synthesizable, so it can drive board LEDs as a lab self-check.
// PARAMETERS
//  N_IN      3           input vector width; table depth = 2^N_IN
//  N_OUT     3           response width
//  SETTLE    2           cycles to wait after accept before sampling (0 legal)
//  EXP_TABLE 24'hF93458  packed expected responses; entry i at [i*N_OUT +: N_OUT]
//                        (default: F1=A&B, F2=A|C, F3=A^B^C; resp_in[2]=F1, vec[2]=A)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        clear statistics, begin a run
//  vec_valid  in   1        vec_in is valid
//  vec_in     in   N_IN     vector applied to the DUT
//  vec_ready  out  1        checker can accept a vector
//  resp_in    in   N_OUT    DUT outputs under test
//  err_count  out  N_IN+1   mismatches this run, saturating at all-ones
//  cov_count  out  N_IN+1   distinct vectors checked this run
//  done       out  1        all 2^N_IN vectors covered
//  pass       out  1        done && err_count==0
//  first_err_vec  out N_IN  vector of the first mismatch (see CONFIGURATION)
//  first_err_resp out N_OUT response observed at the first mismatch
// BEHAVIOUR
//  - Reset: state IDLE; vec_ready, done, pass = 0; err_count, cov_count = 0.
//    Coverage bitmap, first_err_* and the settle counter are all cleared.
//  - FSM states: IDLE, WAIT, SETTLE, CHECK, DONE.
//  - IDLE: vec_ready=0. On start: clear all stats and the bitmap, go to WAIT.
//  - WAIT: vec_ready=1. Accept when vec_valid && vec_ready (cycle T): latch vec_in.
//    If SETTLE>0, go to SETTLE; otherwise go to CHECK.
//  - SETTLE: vec_ready=0. Stay exactly SETTLE cycles (T+1..T+SETTLE), then go to CHECK.
//  - CHECK (cycle T+SETTLE+1): compare resp_in with EXP_TABLE[vec*N_OUT +: N_OUT].
//    * Mismatch: err_count+1 (saturating). On the first mismatch of the run,
//      capture first_err_*.
//    * If the bitmap bit for vec is clear: set it and increment cov_count.
//    * Updated outputs are visible at T+SETTLE+2.
//    * Next state is DONE if cov_count reaches 2^N_IN, else WAIT.
//  - Duplicate vector: it is rechecked and can add errors; coverage is unchanged.
//  - DONE: done=1, vec_ready=0, pass=(err_count==0). Outputs hold until start.
//    start in DONE clears the stats and enters WAIT. start is ignored in WAIT, SETTLE and CHECK.
//  - vec_valid outside WAIT is ignored; no vector is queued.
//  - rst at any cycle, including mid-SETTLE, returns to the reset state on the next edge.
// CONFIGURATION
//  TTC_FIRST_ERR_EN defined: first_err_vec/first_err_resp registers exist as described.
//  Undefined: no capture registers; both ports are tied to 0. All other behaviour is identical.
// TESTING
//  1 rst=1 for 2 cycles -> all outputs 0, vec_ready=0.
//  2 start, then vectors 0..7 with correct responses (000,011,001,010,011,010,110,111)
//    -> done=1, pass=1, err_count=0, cov_count=8.
//    Each accept is followed by vec_ready low for SETTLE+1=3 cycles.
//  3 Same sweep, but vec 5 answers 011 -> err_count=1, pass=0, first_err_vec=5,
//    first_err_resp=011 (0/0 without TTC_FIRST_ERR_EN).
//  4 Send vec 3 twice (second time wrong), then 0..2 and 4..7 -> cov_count=8, err_count=1.
//    The duplicate does not advance coverage.
//  5 rst asserted during SETTLE of vec 4 -> state IDLE, counters 0.
//    Later vec_valid is ignored until start.
//  6 In DONE assert start -> counters and done clear, vec_ready=1 next cycle.

Source files
------------

// File: rtl/truth_table_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : truth_table_checker                                        |
// | Description : Response checker for combinational truth-table benches.    |
// |               Accepts one input vector at a time and waits a settle      |
// |               delay. It then compares the DUT response with a packed     |
// |               expected table, and tracks coverage and mismatches until   |
// |               every vector has been seen.                                |
// | Options     : TTC_FIRST_ERR_EN - when defined, keep registers holding    |
// |               the vector and response of the first mismatch of a run;    |
// |               when undefined, first_err_vec/first_err_resp read 0.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module truth_table_checker #(
   parameter int unsigned                     N_IN      = 3,
   parameter int unsigned                     N_OUT     = 3,
   parameter int unsigned                     SETTLE    = 2,
   parameter logic [(2**N_IN)*N_OUT-1:0]      EXP_TABLE = 24'hF93458
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              vec_valid,
   input  logic [N_IN-1:0]   vec_in,
   output logic              vec_ready,
   input  logic [N_OUT-1:0]  resp_in,
   output logic [N_IN:0]     err_count,
   output logic [N_IN:0]     cov_count,
   output logic              done,
   output logic              pass,
   output logic [N_IN-1:0]   first_err_vec,
   output logic [N_OUT-1:0]  first_err_resp
);

   // ---------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------
   localparam int unsigned DEPTH       = 2**N_IN;
   // Settle counter runs 0..SETTLE-1; keep at least one bit so SETTLE=0
   // and SETTLE=1 still elaborate cleanly.
   localparam int unsigned CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? (SETTLE - 1) : 0;

   localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE_LAST);
   localparam logic [N_IN:0]    ERR_MAX       = {(N_IN+1){1'b1}};
   localparam logic [N_IN:0]    COV_FULL      = (N_IN+1)'(DEPTH);

   // FSM encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // State leaving WAIT: skip the settle phase entirely when SETTLE is 0
   localparam logic [2:0] ST_AFTER_ACCEPT = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;

   // ---------------------------------------------------------------------
   // Expected-response lookup, unpacked from the flat parameter
   // ---------------------------------------------------------------------
   logic [N_OUT-1:0] exp_tab [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_exp
         assign exp_tab[gi] = EXP_TABLE[gi*N_OUT +: N_OUT];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   logic [2:0]        state_q,      state_d;
   logic [N_IN-1:0]   vec_q,        vec_d;
   logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [N_IN:0]     err_q,        err_d;
   logic [N_IN:0]     cov_q,        cov_d;
   logic [DEPTH-1:0]  cov_map_q,    cov_map_d;

   logic              mismatch;
   logic              first_mismatch;
   logic              clear_run;

   // Compare the held vector's expected entry against the live response
   assign mismatch       = (resp_in != exp_tab[vec_q]);
   // First mismatch of a run is the one seen while the error count is still 0
   assign first_mismatch = (state_q == ST_CHECK) && mismatch && (err_q == '0);
   // start is honoured only from IDLE or DONE
   assign clear_run      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Next-state and statistics update
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      settle_cnt_d = settle_cnt_q;
      err_d        = err_q;
      cov_d        = cov_q;
      cov_map_d    = cov_map_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               err_d     = '0;
               cov_d     = '0;
               cov_map_d = '0;
               state_d   = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (vec_valid) begin
               vec_d        = vec_in;
               settle_cnt_d = '0;
               state_d      = ST_AFTER_ACCEPT;
            end
         end

         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST_C) begin
               state_d = ST_CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end

         ST_CHECK: begin
            if (mismatch && (err_q != ERR_MAX)) begin
               err_d = err_q + 1'b1;
            end
            // Duplicates are rechecked but never advance coverage
            if (!cov_map_q[vec_q]) begin
               cov_map_d[vec_q] = 1'b1;
               cov_d            = cov_q + 1'b1;
            end
            state_d = (cov_d == COV_FULL) ? ST_DONE : ST_WAIT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register update with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vec_q        <= '0;
         settle_cnt_q <= '0;
         err_q        <= '0;
         cov_q        <= '0;
         cov_map_q    <= '0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         settle_cnt_q <= settle_cnt_d;
         err_q        <= err_d;
         cov_q        <= cov_d;
         cov_map_q    <= cov_map_d;
      end
   end

   // ---------------------------------------------------------------------
   // First-mismatch capture
   // ---------------------------------------------------------------------
`ifdef TTC_FIRST_ERR_EN
   logic [N_IN-1:0]  first_vec_q,  first_vec_d;
   logic [N_OUT-1:0] first_resp_q, first_resp_d;

   // Capture on the first mismatch; clear whenever a new run begins
   always_comb begin
      first_vec_d  = first_vec_q;
      first_resp_d = first_resp_q;
      if (clear_run) begin
         first_vec_d  = '0;
         first_resp_d = '0;
      end else if (first_mismatch) begin
         first_vec_d  = vec_q;
         first_resp_d = resp_in;
      end
   end

   // Capture registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         first_vec_q  <= '0;
         first_resp_q <= '0;
      end else begin
         first_vec_q  <= first_vec_d;
         first_resp_q <= first_resp_d;
      end
   end

   assign first_err_vec  = first_vec_q;
   assign first_err_resp = first_resp_q;
`else
   // Capture disabled: keep the ports at a defined value
   logic unused_capture;
   assign unused_capture = first_mismatch ^ clear_run;
   assign first_err_vec  = '0;
   assign first_err_resp = '0;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign vec_ready = (state_q == ST_WAIT);
   assign done      = (state_q == ST_DONE);
   assign pass      = done && (err_q == '0);
   assign err_count = err_q;
   assign cov_count = cov_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_truth_table_checker                                     |
// | Description : Self-checking bench for truth_table_checker with default   |
// |               parameters (3-in/3-out table 24'hF93458, SETTLE=2).        |
// |               Honours TTC_FIRST_ERR_EN for first-mismatch expectations.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       vec_valid;
   logic [2:0] vec_in;
   logic       vec_ready;
   logic [2:0] resp_in;
   logic [3:0] err_count;
   logic [3:0] cov_count;
   logic       done;
   logic       pass;
   logic [2:0] first_err_vec;
   logic [2:0] first_err_resp;

   int checks   = 0;
   int failures = 0;

   truth_table_checker dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .vec_valid      (vec_valid),
      .vec_in         (vec_in),
      .vec_ready      (vec_ready),
      .resp_in        (resp_in),
      .err_count      (err_count),
      .cov_count      (cov_count),
      .done           (done),
      .pass           (pass),
      .first_err_vec  (first_err_vec),
      .first_err_resp (first_err_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start_run;
      logic [2:0] vec;
      logic [2:0] resp;
      logic [3:0] exp_err;
      logic [3:0] exp_cov;
   } vec_t;

   vec_t       tbl [25];
   logic [2:0] good [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Wait for vec_ready, hand over one vector, then count the not-ready cycles
   task automatic send(input logic [2:0] v, input logic [2:0] r, output int low_cycles);
      int n;
      n = 0;
      low_cycles = 0;
      while (!vec_ready && n < 20) begin
         step();
         n++;
      end
      if (!vec_ready) begin
         chk("ready_timeout", {31'd0, vec_ready}, 32'd1);
      end else begin
         vec_valid = 1'b1;
         vec_in    = v;
         resp_in   = r;
         step();
         vec_valid = 1'b0;
         while (!vec_ready && !done && low_cycles < 20) begin
            low_cycles++;
            step();
         end
      end
   endtask

   task automatic run_table(input int lo, input int hi);
      int lc;
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].start_run) pulse_start();
         send(tbl[i].vec, tbl[i].resp, lc);
         chk($sformatf("ready_low[%0d]", i), lc, 3);
         chk($sformatf("err[%0d]", i), err_count, tbl[i].exp_err);
         chk($sformatf("cov[%0d]", i), cov_count, tbl[i].exp_cov);
      end
   endtask

   initial begin
      int lc;
      logic [2:0] exp_fv3, exp_fr3, exp_fv4, exp_fr4;

      // Hand-computed correct responses: F1=A&B, F2=A|C, F3=A^B^C
      good[0] = 3'b000; good[1] = 3'b011; good[2] = 3'b001; good[3] = 3'b010;
      good[4] = 3'b011; good[5] = 3'b010; good[6] = 3'b110; good[7] = 3'b111;

      // Run A: clean sweep 0..7
      for (int i = 0; i < 8; i++)
         tbl[i] = '{(i == 0), 3'(i), good[i], 4'd0, 4'(i + 1)};
      // Run B: sweep with vec 5 answering 011
      for (int i = 0; i < 8; i++)
         tbl[8 + i] = '{(i == 0), 3'(i), (i == 5) ? 3'b011 : good[i],
                        (i >= 5) ? 4'd1 : 4'd0, 4'(i + 1)};
      // Run C: vec 3 twice (second wrong), then remaining vectors
      tbl[16] = '{1'b1, 3'd3, 3'b010, 4'd0, 4'd1};
      tbl[17] = '{1'b0, 3'd3, 3'b000, 4'd1, 4'd1};
      tbl[18] = '{1'b0, 3'd0, 3'b000, 4'd1, 4'd2};
      tbl[19] = '{1'b0, 3'd1, 3'b011, 4'd1, 4'd3};
      tbl[20] = '{1'b0, 3'd2, 3'b001, 4'd1, 4'd4};
      tbl[21] = '{1'b0, 3'd4, 3'b011, 4'd1, 4'd5};
      tbl[22] = '{1'b0, 3'd5, 3'b010, 4'd1, 4'd6};
      tbl[23] = '{1'b0, 3'd6, 3'b110, 4'd1, 4'd7};
      tbl[24] = '{1'b0, 3'd7, 3'b111, 4'd1, 4'd8};

`ifdef TTC_FIRST_ERR_EN
      exp_fv3 = 3'd5; exp_fr3 = 3'b011;
      exp_fv4 = 3'd3; exp_fr4 = 3'b000;
`else
      exp_fv3 = 3'd0; exp_fr3 = 3'd0;
      exp_fv4 = 3'd0; exp_fr4 = 3'd0;
`endif

      rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = '0; resp_in = '0;

      // 1: reset for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, vec_ready}, 32'd0);
      chk("rst_done",  {31'd0, done},      32'd0);
      chk("rst_pass",  {31'd0, pass},      32'd0);
      chk("rst_err",   err_count,          32'd0);
      chk("rst_cov",   cov_count,          32'd0);
      chk("rst_fvec",  first_err_vec,      32'd0);
      chk("rst_fresp", first_err_resp,     32'd0);
      rst = 1'b0;
      step();
      chk("idle_ready", {31'd0, vec_ready}, 32'd0);

      // 2: clean sweep
      run_table(0, 7);
      chk("A_done", {31'd0, done}, 32'd1);
      chk("A_pass", {31'd0, pass}, 32'd1);
      chk("A_fvec", first_err_vec, 32'd0);

      // 3: one wrong response
      run_table(8, 15);
      chk("B_done",  {31'd0, done}, 32'd1);
      chk("B_pass",  {31'd0, pass}, 32'd0);
      chk("B_fvec",  first_err_vec,  exp_fv3);
      chk("B_fresp", first_err_resp, exp_fr3);

      // 4: duplicate vector
      run_table(16, 24);
      chk("C_done",  {31'd0, done}, 32'd1);
      chk("C_pass",  {31'd0, pass}, 32'd0);
      chk("C_fvec",  first_err_vec,  exp_fv4);
      chk("C_fresp", first_err_resp, exp_fr4);

      // 6: start from DONE clears the run
      pulse_start();
      chk("restart_ready", {31'd0, vec_ready}, 32'd1);
      chk("restart_done",  {31'd0, done},      32'd0);
      chk("restart_err",   err_count,          32'd0);
      chk("restart_cov",   cov_count,          32'd0);
      chk("restart_fvec",  first_err_vec,      32'd0);
      chk("restart_fresp", first_err_resp,     32'd0);

      // Error counter saturation: 16 wrong duplicates of vec 0
      for (int i = 0; i < 15; i++) send(3'd0, 3'b101, lc);
      chk("sat_err15", err_count, 32'd15);
      send(3'd0, 3'b101, lc);
      chk("sat_err_hold", err_count, 32'd15);
      chk("sat_cov", cov_count, 32'd1);
      // start in WAIT is ignored
      pulse_start();
      chk("wait_start_err",   err_count,          32'd15);
      chk("wait_start_ready", {31'd0, vec_ready}, 32'd1);

      // 5: reset during SETTLE of vec 4
      rst = 1'b1;
      step();
      rst = 1'b0;
      pulse_start();
      for (int i = 0; i < 4; i++) send(3'(i), good[i], lc);
      chk("pre_rst_cov", cov_count, 32'd4);
      vec_valid = 1'b1; vec_in = 3'd4; resp_in = good[4];
      step();
      vec_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_ready", {31'd0, vec_ready}, 32'd0);
      chk("midrst_cov",   cov_count,          32'd0);
      chk("midrst_err",   err_count,          32'd0);
      chk("midrst_done",  {31'd0, done},      32'd0);
      // vec_valid in IDLE is not accepted
      vec_valid = 1'b1; vec_in = 3'd1; resp_in = 3'b000;
      repeat (3) step();
      chk("idle_valid_ready", {31'd0, vec_ready}, 32'd0);
      chk("idle_valid_cov",   cov_count,          32'd0);
      chk("idle_valid_err",   err_count,          32'd0);
      vec_valid = 1'b0;
      pulse_start();
      chk("post_start_ready", {31'd0, vec_ready}, 32'd1);
      chk("post_start_cov",   cov_count,          32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
